// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns one single-cycle response per accepted command.
//
// Ports
//   pclk, preset_n        clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_write, cmd_addr, cmd_wdata)
//   rsp_valid             one-cycle response pulse with rsp_rdata,
//                         rsp_slverr, rsp_timeout
//   psel .. pwdata        APB requester outputs (registered)
//   prdata, pready,
//   pslverr               APB completer inputs

module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] LAST =
    TO_EN ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic          expire;

  // Ready in IDLE, or on the ACCESS completion edge so that
  // back-to-back transfers skip the IDLE cycle.
  assign cmd_ready = (state == IDLE)
                  || ((state == ACCESS) && pready);

  // Abort on the TIMEOUT-th wait-state edge of ACCESS.
  assign expire = TO_EN
               && (state == ACCESS)
               && !pready
               && (wcnt == LAST);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          wcnt    <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
            if (cmd_valid) begin
              // psel stays high into the next SETUP
              pwrite  <= cmd_write;
              paddr   <= cmd_addr;
              pwdata  <= cmd_wdata;
              penable <= 1'b0;
              state   <= SETUP;
            end else begin
              psel    <= 1'b0;
              penable <= 1'b0;
              state   <= IDLE;
            end
          end else if (expire) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= IDLE;
          end else if (wcnt != '1) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
